data_bus_arbiter: RTL and testbench



---
 rtl/data_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_data_bus_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_arbiter
// Brief    : Two-master round-robin arbiter for the data-memory req/gnt/rvalid
//            port, with an ID FIFO routing in-order responses back to issuers.
//            Define DATA_ARB_FIXED_PRIO_EN to give m0 fixed priority instead.
// Revision : 1.0
// ============================================================================
module data_bus_arbiter #(
    parameter int BUS_AW          = 32,
    parameter int BUS_DW          = 32,
    parameter int BUS_DBW         = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m0_req_i,
    input  logic [BUS_AW-1:0]  m0_addr_i,
    input  logic               m0_we_i,
    input  logic [BUS_DBW-1:0] m0_be_i,
    input  logic [BUS_DW-1:0]  m0_wdata_i,
    output logic               m0_gnt_o,
    output logic               m0_rvalid_o,
    output logic [BUS_DW-1:0]  m0_rdata_o,
    input  logic               m1_req_i,
    input  logic [BUS_AW-1:0]  m1_addr_i,
    input  logic               m1_we_i,
    input  logic [BUS_DBW-1:0] m1_be_i,
    input  logic [BUS_DW-1:0]  m1_wdata_i,
    output logic               m1_gnt_o,
    output logic               m1_rvalid_o,
    output logic [BUS_DW-1:0]  m1_rdata_o,
    output logic               data_req_o,
    output logic [BUS_AW-1:0]  data_addr_o,
    output logic               data_we_o,
    output logic [BUS_DBW-1:0] data_be_o,
    output logic [BUS_DW-1:0]  data_wdata_o,
    input  logic               data_gnt_i,
    input  logic               data_rvalid_i,
    input  logic [BUS_DW-1:0]  data_rdata_i,
    output logic               arb_err_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_HOLD_M0 = 2'd1;
    localparam logic [1:0] ARB_HOLD_M1 = 2'd2;

    logic [1:0]    r_state;
    logic          r_ids [MAX_OUTSTANDING];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_err;

    logic          w_full;
    logic          w_sel;
    logic          w_sel_valid;
    logic          w_req;
    logic          w_prio_m1;
    logic          w_push;
    logic          w_pop;
    logic          w_head;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;

`ifdef DATA_ARB_FIXED_PRIO_EN
    assign w_prio_m1 = 1'b0;
`else
    logic r_rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_push) begin
            r_rr_ptr <= ~w_sel;
        end
    end

    assign w_prio_m1 = r_rr_ptr;
`endif

    assign w_full = (r_count == CW'(MAX_OUTSTANDING));

    // A locked HOLD state keeps the selection even while the FIFO is full; only the request is masked.
    always_comb begin
        w_sel       = 1'b0;
        w_sel_valid = 1'b0;
        w_req       = 1'b0;
        case (r_state)
            ARB_HOLD_M0: begin
                w_sel_valid = 1'b1;
                w_req       = m0_req_i && !w_full;
            end
            ARB_HOLD_M1: begin
                w_sel       = 1'b1;
                w_sel_valid = 1'b1;
                w_req       = m1_req_i && !w_full;
            end
            default: begin
                if (!w_full && (m0_req_i || m1_req_i)) begin
                    w_sel_valid = 1'b1;
                    w_req       = 1'b1;
                    w_sel       = (m0_req_i && m1_req_i) ? w_prio_m1 : m1_req_i;
                end
            end
        endcase
    end

    assign data_req_o   = w_req;
    assign data_addr_o  = !w_sel_valid ? '0 : (w_sel ? m1_addr_i  : m0_addr_i);
    assign data_we_o    = w_sel_valid && (w_sel ? m1_we_i : m0_we_i);
    assign data_be_o    = !w_sel_valid ? '0 : (w_sel ? m1_be_i    : m0_be_i);
    assign data_wdata_o = !w_sel_valid ? '0 : (w_sel ? m1_wdata_i : m0_wdata_i);

    assign w_push   = w_req && data_gnt_i;
    assign w_pop    = data_rvalid_i && (r_count != '0);
    assign w_head   = r_ids[r_rptr];
    assign m0_gnt_o = w_push && !w_sel;
    assign m1_gnt_o = w_push &&  w_sel;

    assign m0_rvalid_o = w_pop && !w_head;
    assign m1_rvalid_o = w_pop &&  w_head;
    assign m0_rdata_o  = w_pop ? data_rdata_i : '0;
    assign m1_rdata_o  = w_pop ? data_rdata_i : '0;
    assign arb_err_o   = r_err;

    assign w_wptr_nxt = (r_wptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wptr + PW'(1);
    assign w_rptr_nxt = (r_rptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rptr + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ARB_HOLD_M0: begin
                    if (!m0_req_i) begin
                        r_err   <= 1'b1;
                        r_state <= ARB_IDLE;
                    end else if (w_push) begin
                        r_state <= ARB_IDLE;
                    end
                end
                ARB_HOLD_M1: begin
                    if (!m1_req_i) begin
                        r_err   <= 1'b1;
                        r_state <= ARB_IDLE;
                    end else if (w_push) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    if (w_sel_valid && !data_gnt_i) begin
                        r_state <= w_sel ? ARB_HOLD_M1 : ARB_HOLD_M0;
                    end else begin
                        r_state <= ARB_IDLE;
                    end
                end
            endcase
            // A response with nothing outstanding is dropped.
            if (data_rvalid_i && (r_count == '0)) begin
                r_err <= 1'b1;
            end
            if (w_push) begin
                r_ids[r_wptr] <= w_sel;
                r_wptr        <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_arbiter
// Brief    : Directed self-checking bench for data_bus_arbiter.
// Revision : 1.0
// ============================================================================
module tb_data_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid, arb_err;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;
    logic [5:0]  ctl;

    int checks = 0;
    int errors = 0;

    data_bus_arbiter #(
        .BUS_AW(32), .BUS_DW(32), .BUS_DBW(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .data_req_o(data_req), .data_addr_o(data_addr), .data_we_o(data_we), .data_be_o(data_be),
        .data_wdata_o(data_wdata), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
        .data_rdata_i(data_rdata), .arb_err_o(arb_err)
    );

    // {data_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, arb_err}
    assign ctl = {data_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, arb_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        m0_be = 4'hF; m1_be = 4'hF;
        data_gnt = 0; data_rvalid = 0; data_rdata = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000000) begin
            errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b000000);
        end
        checks++;
        if ({data_addr, data_we, data_be, data_wdata} !== 69'd0) begin
            errors++; $display("FAIL reset_payload: got addr %h be %h expected 0", data_addr, data_be);
        end
        tick();
    endtask

    task automatic test_round_robin;
        logic       w, prev;
        logic [5:0] exp;
        logic [31:0] exp_addr, exp_data, got_data;
        m0_addr = 32'h10; m1_addr = 32'h20;
        m0_req = 1; m1_req = 1; data_gnt = 1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
`ifdef DATA_ARB_FIXED_PRIO_EN
            w = 1'b0;
`else
            w = (i % 2) == 1;
`endif
            data_rvalid = (i > 0);
            exp_data    = prev ? 32'h5A5A_0001 : 32'hA5A5_0000;
            data_rdata  = (i > 0) ? exp_data : 32'h0;
            @(negedge clk);
            exp = {1'b1, !w, w, (i > 0) && !prev, (i > 0) && prev, 1'b0};
            exp_addr = w ? 32'h20 : 32'h10;
            checks++;
            if (ctl !== exp) begin
                errors++; $display("FAIL rr_ctl[%0d]: got %b expected %b", i, ctl, exp);
            end
            checks++;
            if (data_addr !== exp_addr) begin
                errors++; $display("FAIL rr_addr[%0d]: got %h expected %h", i, data_addr, exp_addr);
            end
            if (i > 0) begin
                got_data = prev ? m1_rdata : m0_rdata;
                checks++;
                if (got_data !== exp_data) begin
                    errors++; $display("FAIL rr_rdata[%0d]: got %h expected %h", i, got_data, exp_data);
                end
            end
            tick();
            prev = w;
        end
        m0_req = 0; m1_req = 0; data_gnt = 0;
        data_rvalid = 1; data_rdata = prev ? 32'h5A5A_0001 : 32'hA5A5_0000;
        @(negedge clk);
        exp = {3'b000, !prev, prev, 1'b0};
        checks++;
        if (ctl !== exp) begin
            errors++; $display("FAIL rr_drain: got %b expected %b", ctl, exp);
        end
        tick();
        data_rvalid = 0;
    endtask

    task automatic test_hold;
        m1_req = 1; m1_addr = 32'h100; m0_req = 0; m0_addr = 32'h40; data_gnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) m0_req = 1;
            if (i == 3) data_gnt = 1;
            @(negedge clk);
            checks++;
            if (ctl !== {2'b10, i == 3, 3'b000}) begin
                errors++; $display("FAIL hold_ctl[%0d]: got %b expected %b", i, ctl, {2'b10, i == 3, 3'b000});
            end
            checks++;
            if (data_addr !== 32'h100) begin
                errors++; $display("FAIL hold_addr[%0d]: got %h expected %h", i, data_addr, 32'h100);
            end
            tick();
        end
        m1_req = 0;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b110000 || data_addr !== 32'h40) begin
            errors++; $display("FAIL hold_after: got %b/%h expected %b/%h", ctl, data_addr, 6'b110000, 32'h40);
        end
        tick();
        m0_req = 0; data_gnt = 0; data_rvalid = 1; data_rdata = 32'h11;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000010 || m1_rdata !== 32'h11) begin
            errors++; $display("FAIL hold_resp_m1: got %b/%h expected %b/%h", ctl, m1_rdata, 6'b000010, 32'h11);
        end
        tick();
        data_rdata = 32'h22;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000100 || m0_rdata !== 32'h22) begin
            errors++; $display("FAIL hold_resp_m0: got %b/%h expected %b/%h", ctl, m0_rdata, 6'b000100, 32'h22);
        end
        tick();
        data_rvalid = 0;
    endtask

    task automatic test_full;
        logic       w5;
        logic [5:0] exp;
`ifdef DATA_ARB_FIXED_PRIO_EN
        w5 = 1'b0;
`else
        w5 = 1'b1;
`endif
        m1_req = 1; m1_addr = 32'h200; m0_req = 0; data_gnt = 1;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b101000) begin
            errors++; $display("FAIL full_push1: got %b expected %b", ctl, 6'b101000);
        end
        tick();
        m1_req = 0; m0_req = 1; m0_addr = 32'h204; m0_we = 1; m0_wdata = 32'hCAFE;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b110000 || data_we !== 1'b1 || data_wdata !== 32'hCAFE) begin
            errors++; $display("FAIL full_push2: got %b we %b wd %h expected %b we 1 wd cafe", ctl, data_we, data_wdata, 6'b110000);
        end
        tick();
        m1_req = 1;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000000 || data_addr !== 32'h0) begin
            errors++; $display("FAIL full_block: got %b/%h expected %b/0", ctl, data_addr, 6'b000000);
        end
        tick();
        data_rvalid = 1; data_rdata = 32'h33;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000010 || m1_rdata !== 32'h33) begin
            errors++; $display("FAIL full_pop_nobypass: got %b/%h expected %b/%h", ctl, m1_rdata, 6'b000010, 32'h33);
        end
        tick();
        data_rvalid = 0;
        @(negedge clk);
        exp = {1'b1, !w5, w5, 3'b000};
        checks++;
        if (ctl !== exp || data_addr !== (w5 ? 32'h200 : 32'h204)) begin
            errors++; $display("FAIL full_resume: got %b/%h expected %b", ctl, data_addr, exp);
        end
        tick();
        m0_req = 0; m1_req = 0; m0_we = 0; data_gnt = 0; data_rvalid = 1; data_rdata = 32'h44;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000100 || m0_rdata !== 32'h44) begin
            errors++; $display("FAIL full_write_resp: got %b/%h expected %b/%h", ctl, m0_rdata, 6'b000100, 32'h44);
        end
        tick();
        @(negedge clk);
        exp = {3'b000, !w5, w5, 1'b0};
        checks++;
        if (ctl !== exp) begin
            errors++; $display("FAIL full_last_resp: got %b expected %b", ctl, exp);
        end
        tick();
        data_rvalid = 0;
    endtask

    task automatic test_err_empty;
        data_rvalid = 1; data_rdata = 32'hDEAD;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000000) begin
            errors++; $display("FAIL err_drop: got %b expected %b", ctl, 6'b000000);
        end
        tick();
        data_rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ctl !== 6'b000001) begin
                errors++; $display("FAIL err_sticky[%0d]: got %b expected %b", i, ctl, 6'b000001);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        m1_req = 1; m1_addr = 32'h300; data_gnt = 1;
        tick();
        m1_req = 0; m0_req = 1; m0_addr = 32'h304;
        tick();
        m1_req = 1; data_gnt = 0;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000001) begin
            errors++; $display("FAIL mid_full: got %b expected %b", ctl, 6'b000001);
        end
        rst = 1;
        tick();
        rst = 0; m0_req = 0; m1_req = 0;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000000 || data_addr !== 32'h0) begin
            errors++; $display("FAIL mid_after_rst: got %b/%h expected %b/0", ctl, data_addr, 6'b000000);
        end
        tick();
        m0_req = 1; m1_req = 1; data_gnt = 1;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b110000) begin
            errors++; $display("FAIL mid_rr_cleared: got %b expected %b", ctl, 6'b110000);
        end
        tick();
        m0_req = 0; m1_req = 0; data_gnt = 0; data_rvalid = 1; data_rdata = 32'h55;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000100) begin
            errors++; $display("FAIL mid_fifo_cleared: got %b expected %b", ctl, 6'b000100);
        end
        tick();
        data_rvalid = 0;
    endtask

    task automatic test_hold_drop;
        m1_req = 1; m1_addr = 32'h100; data_gnt = 0;
        tick();
        m1_req = 0; m0_req = 1; m0_addr = 32'h40;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000000) begin
            errors++; $display("FAIL drop_locked: got %b expected %b", ctl, 6'b000000);
        end
        tick();
        data_gnt = 1;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b110001 || data_addr !== 32'h40) begin
            errors++; $display("FAIL drop_err: got %b/%h expected %b/%h", ctl, data_addr, 6'b110001, 32'h40);
        end
        tick();
        m0_req = 0; data_gnt = 0; data_rvalid = 1;
        @(negedge clk);
        checks++;
        if (ctl !== 6'b000101) begin
            errors++; $display("FAIL drop_resp: got %b expected %b", ctl, 6'b000101);
        end
        tick();
        data_rvalid = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_hold();
        test_full();
        test_err_empty();
        test_reset_mid();
        test_hold_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
